part_hist: RTL and testbench
============================

Name: part_hist

Overview:
- Per-channel partial histogram engine.
- Each frame delivers N_CH packed sample codes on data_in_V, one code per channel.
- Over `accumulation_V` frames, keeps a CODE-bin histogram per channel.
- At the end of each accumulation window, streams one (mode, frequency) pair per channel into two downstream FIFOs, clears the histograms and restarts.
- Sits between the front-end sample packer and the readout FIFOs; uses an HLS-style ap_ctrl handshake.

Parameters:
- N_CH, 23, number of channels (lanes) in data_in_V.
- CODE_W, 5, bits per sample code; 2**CODE_W bins per channel.
- CNT_W, 16, bin counter width; also the output data width.

Ports:
- ap_clk  in  1  single clock; all logic on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  level enable; block runs continuously while high.
- ap_done  out  1  one-cycle pulse when a window's last output pair is written.
- ap_idle  out  1  high when in IDLE and ap_start low.
- ap_ready  out  1  pulses together with ap_done.
- data_in_V  in  N_CH*CODE_W (115)  packed codes; channel c occupies bits [c*CODE_W +: CODE_W].
- input_valid_V  in  1  frame strobe; a frame is taken on its rising edge only.
- accumulation_V  in  32  frames per window; value 0 is treated as 1; sampled at window start.
- frequency_out_V_V_din  out  16  count of the mode bin.
- frequency_out_V_V_full_n  in  1  frequency FIFO not full.
- frequency_out_V_V_write  out  1  frequency FIFO write strobe.
- mode_out_V_V_din  out  16  mode bin index.
- mode_out_V_V_full_n  in  1  mode FIFO not full.
- mode_out_V_V_write  out  1  mode FIFO write strobe.

Behaviour:
- Storage: N_CH banks of 2**CODE_W counters of CNT_W bits. All channels update in parallel.
- Reset values:
  - All outputs are 0 during reset.
  - State = CLEAR; frame counter = 0; bin pointer = 0.
  - The edge-detect register for input_valid_V resets to 0.
- State machine:
  - CLEAR: zeroes bin[ptr] in every bank, one bin per cycle, for 2**CODE_W cycles. Goes to IDLE.
  - IDLE: waits for ap_start=1, then latches max(accumulation_V,1) and goes to ACCUM.
  - ACCUM: on each input_valid_V rising edge (valid & ~valid_d), captures data_in_V. On the next cycle, increments bin[code_c] in every bank c; counters saturate at 2**CNT_W-1. The frame counter increments. When it reaches the latched accumulation value, go to SCAN.
  - SCAN: walks bin index 0..2**CODE_W-1, one per cycle. Each bank keeps a running max; a bin replaces the max only if strictly greater, so ties resolve to the lowest bin index. Each bin is cleared immediately after it is read. Goes to EMIT.
  - EMIT: emits channels 0..N_CH-1 in order. For each channel, both write strobes assert in the same cycle, and only when both full_n are 1; otherwise the pair stalls, holding its data. After the last channel, pulse ap_done/ap_ready for one cycle. Then go to IDLE, or directly to ACCUM if ap_start is still high, re-latching accumulation_V.
- Output values:
  - mode_out_V_V_din = mode bin index, zero-extended to 16 bits.
  - frequency_out_V_V_din = its count.
  - An all-zero histogram emits mode 0, frequency 0.
- Latency:
  - Counts are updated 2 cycles after the strobe edge.
  - Window end to first write is 2**CODE_W+2 cycles.
  - A window with no back-pressure completes in about 60 cycles.
- Frame drop: strobe edges arriving in CLEAR, IDLE, SCAN or EMIT are ignored. Frames are not buffered.
- Level hold: a strobe held high counts as exactly one frame.
- ap_start dropping mid-window: the current window finishes (accumulate, scan, emit); then the block stops in IDLE.
- Mid-operation reset: asynchronous return to CLEAR; all counts are lost.

Optional Feature:
- Macro: PART_HIST_CH_TAG_EN.
- Defined: mode_out_V_V_din[15:8] = channel index and [7:0] = mode bin index, for downstream channel tagging.
- Undefined: mode_out_V_V_din is the bin index zero-extended; the channel is implied by write order.

Decomposition:
- Package part_hist_pkg holds:
  - N_CH, CODE_W, CNT_W, NBINS = 2**CODE_W;
  - the state enum (CLEAR, IDLE, ACCUM, SCAN, EMIT);
  - the saturating-increment function.
- One sub-module, part_hist_bank, generated N_CH times. Each instance holds one channel's counter array, increment port, read-and-clear scan port, and running max/argmax.

Test Plan:
- Reset for 100 cycles, then ap_start=1. Expect: ap_idle=0 within 1 cycle; no FIFO writes; CLEAR completes in 32 cycles.
- accumulation_V=12, data_in_V all channels code 7, 12 strobes of 2 cycles each, 350-cycle spacing. Expect: 23 write pairs, each mode=7 and freq=12; one ap_done pulse.
- Channel 0 gets code 3 for 5 frames and code 9 for 7 frames; channel 1 gets codes 4/6 for 6 frames each; accumulation 12. Expect: ch0 mode=9 freq=7; ch1 mode=4 freq=6 (tie goes to the lower bin).
- 10 strobes, a 13.5 us gap, then 5 more with accumulation 12. Expect: the window closes on the 12th strobe. The remaining 3 strobes start a fresh window whose counts reflect only those 3 frames, proving the clear worked.
- Hold mode_out_V_V_full_n=0 for 20 cycles during EMIT. Expect: no writes while held; data held stable; all 23 pairs delivered in order afterwards.
- Assert ap_rst mid-ACCUM, then run a new 12-frame window. Expect: outputs go to 0 immediately; the new window's freq=12 with no leftover counts.

Source files
------------

// File: rtl/part_hist_pkg.sv
// Shared sizes, FSM state codes and the saturating counter helper for part_hist.
package part_hist_pkg;

    localparam int unsigned N_CH   = 23;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NBINS  = 2 ** CODE_W;
    localparam int unsigned DATA_W = N_CH * CODE_W;
    localparam int unsigned CH_W   = 5;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned ACC_W  = 32;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/part_hist_bank.sv
// One channel's bin counters with increment, clear, and read-and-clear scan
// that tracks the running maximum (ties keep the lowest bin index).
module part_hist_bank
    import part_hist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_en,
    input  logic              scan_en,
    input  logic [CODE_W-1:0] ptr,
    input  logic              inc_en,
    input  logic [CODE_W-1:0] inc_idx,
    output logic [CNT_W-1:0]  max_cnt,
    output logic [CODE_W-1:0] max_idx
);

    logic [CNT_W-1:0]  bins_q [NBINS];
    logic [CNT_W-1:0]  bins_d [NBINS];
    logic [CNT_W-1:0]  max_cnt_q, max_cnt_d;
    logic [CODE_W-1:0] max_idx_q, max_idx_d;

    always_comb begin
        bins_d    = bins_q;
        max_cnt_d = max_cnt_q;
        max_idx_d = max_idx_q;
        if (clr_en) begin
            bins_d[ptr] = '0;
        end else if (inc_en) begin
            bins_d[inc_idx] = sat_inc(bins_q[inc_idx]);
        end else if (scan_en) begin
            bins_d[ptr] = '0;
            // bin 0 seeds the maximum; later bins win only when strictly larger
            if ((ptr == '0) || (bins_q[ptr] > max_cnt_q)) begin
                max_cnt_d = bins_q[ptr];
                max_idx_d = ptr;
            end
        end
    end

    // Counter storage is cleared by the CLEAR walk, so it needs no reset.
    always_ff @(posedge clk) begin
        bins_q <= bins_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_cnt_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_cnt_q <= max_cnt_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_cnt = max_cnt_q;
    assign max_idx = max_idx_q;

endmodule

// File: rtl/part_hist.sv
// Per-channel partial histogram: accumulate frames, scan for mode, emit (mode, freq) pairs.
// Define PART_HIST_CH_TAG_EN to place the channel index in mode_out_V_V_din[15:8].
module part_hist
    import part_hist_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] data_in_V,
    input  logic              input_valid_V,
    input  logic [ACC_W-1:0]  accumulation_V,
    output logic [OUT_W-1:0]  frequency_out_V_V_din,
    input  logic              frequency_out_V_V_full_n,
    output logic              frequency_out_V_V_write,
    output logic [OUT_W-1:0]  mode_out_V_V_din,
    input  logic              mode_out_V_V_full_n,
    output logic              mode_out_V_V_write
);

    logic [2:0]        state_q, state_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [ACC_W-1:0]  frame_q, frame_d, acc_q, acc_d, start_acc;
    logic [CH_W-1:0]   ch_q, ch_d, sel_ch;
    logic              pend_q, pend_d, cap_q, cap_d, valid_q;
    logic              done_q, done_d, idle_q, idle_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OUT_W-1:0]  freq_q, freq_d, mode_q, mode_d;
    logic              clr_en, scan_en, load, fifo_ok, last_ch;
    logic [CNT_W-1:0]  max_cnt [N_CH];
    logic [CODE_W-1:0] max_idx [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_bank
        part_hist_bank u_bank (
            .clk     (ap_clk),
            .rst     (ap_rst),
            .clr_en  (clr_en),
            .scan_en (scan_en),
            .ptr     (ptr_q),
            .inc_en  (cap_q),
            .inc_idx (data_q[c*CODE_W +: CODE_W]),
            .max_cnt (max_cnt[c]),
            .max_idx (max_idx[c])
        );
    end

    assign start_acc = (accumulation_V == '0) ? ACC_W'(1) : accumulation_V;
    assign fifo_ok   = mode_out_V_V_full_n & frequency_out_V_V_full_n;
    assign last_ch   = (ch_q == CH_W'(N_CH - 1));
    // A pending pair being written this cycle hands the din registers to the next channel
    assign sel_ch    = (pend_q && !last_ch) ? ch_q + CH_W'(1) : ch_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        frame_d = frame_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        cap_d   = 1'b0;
        data_d  = data_q;
        freq_d  = freq_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        clr_en  = 1'b0;
        scan_en = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_CLEAR: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + CODE_W'(1);
                if (ptr_q == CODE_W'(NBINS - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (ap_start) begin
                    acc_d   = start_acc;
                    frame_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (input_valid_V && !valid_q) begin
                    cap_d  = 1'b1;
                    data_d = data_in_V;
                end
                if (cap_q) begin
                    frame_d = frame_q + ACC_W'(1);
                    if (frame_q + ACC_W'(1) == acc_q) begin
                        ptr_d   = '0;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
                ptr_d   = ptr_q + CODE_W'(1);
                if (ptr_q == CODE_W'(NBINS - 1)) begin
                    ch_d    = '0;
                    pend_d  = 1'b0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!pend_q) begin
                    load   = 1'b1;
                    pend_d = 1'b1;
                end else if (fifo_ok) begin
                    if (last_ch) begin
                        pend_d = 1'b0;
                        done_d = 1'b1;
                        if (ap_start) begin
                            acc_d   = start_acc;
                            frame_d = '0;
                            state_d = S_ACCUM;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                        load = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase

        if (load) begin
            freq_d = OUT_W'(max_cnt[sel_ch]);
`ifdef PART_HIST_CH_TAG_EN
            mode_d = {8'(sel_ch), 8'(max_idx[sel_ch])};
`else
            mode_d = OUT_W'(max_idx[sel_ch]);
`endif
        end

        idle_d = (state_d == S_IDLE) && !ap_start;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            frame_q <= '0;
            acc_q   <= '0;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            cap_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            freq_q  <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            cap_q   <= cap_d;
            valid_q <= input_valid_V;
            data_q  <= data_d;
            freq_q  <= freq_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign ap_done                 = done_q;
    assign ap_ready                = done_q;
    assign ap_idle                 = idle_q;
    assign frequency_out_V_V_din   = freq_q;
    assign mode_out_V_V_din        = mode_q;
    // Strobes gate the held pair with live full_n so no write lands on a full FIFO
    assign mode_out_V_V_write      = pend_q & fifo_ok;
    assign frequency_out_V_V_write = pend_q & fifo_ok;

endmodule

// File: tb/tb_part_hist.sv
// Directed bench for part_hist: table of accumulation windows plus hand-written
// reset, frame-drop, back-pressure and mid-window reset sequences.
module tb_part_hist;

    localparam int NCH = 23;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic         ap_start = 1'b0;
    logic         ap_done, ap_idle, ap_ready;
    logic [114:0] data_in_V = '0;
    logic         input_valid_V = 1'b0;
    logic [31:0]  accumulation_V = 32'd0;
    logic [15:0]  frequency_out_V_V_din, mode_out_V_V_din;
    logic         frequency_out_V_V_full_n = 1'b1;
    logic         mode_out_V_V_full_n = 1'b1;
    logic         frequency_out_V_V_write, mode_out_V_V_write;

    part_hist dut (
        .ap_clk                   (ap_clk),
        .ap_rst                   (ap_rst),
        .ap_start                 (ap_start),
        .ap_done                  (ap_done),
        .ap_idle                  (ap_idle),
        .ap_ready                 (ap_ready),
        .data_in_V                (data_in_V),
        .input_valid_V            (input_valid_V),
        .accumulation_V           (accumulation_V),
        .frequency_out_V_V_din    (frequency_out_V_V_din),
        .frequency_out_V_V_full_n (frequency_out_V_V_full_n),
        .frequency_out_V_V_write  (frequency_out_V_V_write),
        .mode_out_V_V_din         (mode_out_V_V_din),
        .mode_out_V_V_full_n      (mode_out_V_V_full_n),
        .mode_out_V_V_write       (mode_out_V_V_write)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int unsigned acc;
        int unsigned nfr;
        int unsigned gap;
        logic [4:0]  c0a, c0b;
        int unsigned n0a;
        logic [4:0]  c1a, c1b;
        int unsigned n1a;
        logic [4:0]  cr;
        logic [4:0]  e0m;
        logic [15:0] e0f;
        logic [4:0]  e1m;
        logic [15:0] e1f;
        logic [4:0]  erm;
        logic [15:0] erf;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] mq [$];
    logic [15:0] fq [$];
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collects every written pair and audits the write handshake.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (mode_out_V_V_write || frequency_out_V_V_write) begin
                check("write_pair", 32'(mode_out_V_V_write), 32'(frequency_out_V_V_write));
                check("write_full_n", 32'(mode_out_V_V_full_n & frequency_out_V_V_full_n), 32'd1);
                if (mode_out_V_V_write) begin
                    mq.push_back(mode_out_V_V_din);
                    fq.push_back(frequency_out_V_V_din);
                end
            end
            if (ap_done || ap_ready) begin
                check("done_ready", 32'(ap_done), 32'(ap_ready));
                if (ap_done) done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #2;
        end
    endtask

    function automatic logic [114:0] mk(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] cr);
        logic [114:0] d;
        d = '0;
        for (int c = 0; c < NCH; c++) d[c*5 +: 5] = (c == 0) ? c0 : ((c == 1) ? c1 : cr);
        return d;
    endfunction

    function automatic logic [15:0] exp_mode(input int c, input logic [4:0] m);
`ifdef PART_HIST_CH_TAG_EN
        return {8'(c), 3'b000, m};
`else
        return {11'b0, m};
`endif
    endfunction

    task automatic strobe(input logic [114:0] d, input int gap);
        data_in_V     = d;
        input_valid_V = 1'b1;
        tick(2);
        input_valid_V = 1'b0;
        tick(gap);
    endtask

    task automatic wait_done(input int target, input int bound);
        int n;
        n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge ap_clk);
            n++;
        end
        check("done_timeout", 32'(done_cnt >= target), 32'd1);
        tick(3);
    endtask

    task automatic check_pair(input int idx, input int c, input logic [4:0] em, input logic [15:0] ef);
        logic [15:0] am, af;
        am = (idx < mq.size()) ? mq[idx] : 16'hFFFF;
        af = (idx < fq.size()) ? fq[idx] : 16'hFFFF;
        check($sformatf("ch%0d_mode", c), 32'(am), 32'(exp_mode(c, em)));
        check($sformatf("ch%0d_freq", c), 32'(af), 32'(ef));
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (ap_idle && n < 20) begin
            tick(1);
            n++;
        end
        check("start_idle", 32'(ap_idle), 32'd0);
    endtask

    task automatic run_row(input vec_t v);
        int base, d0;
        logic [4:0] c0, c1;
        accumulation_V = v.acc;
        ap_start = 1'b1;
        wait_busy();
        ap_start = 1'b0;
        base = mq.size();
        d0   = done_cnt;
        for (int f = 0; f < int'(v.nfr); f++) begin
            c0 = (f < int'(v.n0a)) ? v.c0a : v.c0b;
            c1 = (f < int'(v.n1a)) ? v.c1a : v.c1b;
            strobe(mk(c0, c1, v.cr), int'(v.gap));
        end
        wait_done(d0 + 1, 300);
        check("pair_count", 32'(mq.size()), 32'(base + NCH));
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
        check_pair(base, 0, v.e0m, v.e0f);
        check_pair(base + 1, 1, v.e1m, v.e1f);
        for (int c = 2; c < NCH; c++) check_pair(base + c, c, v.erm, v.erf);
    endtask

    initial begin
        int n, base, d0, sz;
        logic [15:0] held_m, held_f;
        logic stable;
        logic [114:0] d;

        vecs[0] = '{12, 12, 350, 5'd7, 5'd7, 12, 5'd7, 5'd7, 12, 5'd7,
                    5'd7, 16'd12, 5'd7, 16'd12, 5'd7, 16'd12};
        vecs[1] = '{12, 12, 4, 5'd3, 5'd9, 5, 5'd4, 5'd6, 6, 5'd31,
                    5'd9, 16'd7, 5'd4, 16'd6, 5'd31, 16'd12};
        vecs[2] = '{0, 1, 4, 5'd0, 5'd0, 1, 5'd5, 5'd5, 1, 5'd2,
                    5'd0, 16'd1, 5'd5, 16'd1, 5'd2, 16'd1};
        vecs[3] = '{3, 3, 4, 5'd31, 5'd31, 3, 5'd0, 5'd1, 1, 5'd16,
                    5'd31, 16'd3, 5'd1, 16'd2, 5'd16, 16'd3};

        // Reset state and CLEAR duration
        tick(100);
        check("rst_outputs", {ap_done, ap_idle, ap_ready, mode_out_V_V_write, frequency_out_V_V_write,
                              mode_out_V_V_din, frequency_out_V_V_din}, 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        n = 0;
        while (!ap_idle && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check("clear_cycles", 32'(n), 32'd32);
        tick(1);

        // Strobes while IDLE must not count
        strobe(mk(5'd13, 5'd13, 5'd13), 4);
        strobe(mk(5'd13, 5'd13, 5'd13), 4);
        check("idle_no_write", 32'(mq.size()), 32'd0);

        for (int i = 0; i < 4; i++) run_row(vecs[i]);

        // Window closes on the 12th strobe; the next 3 start a fresh window
        accumulation_V = 32'd12;
        ap_start = 1'b1;
        wait_busy();
        accumulation_V = 32'd3;
        base = mq.size();
        d0   = done_cnt;
        for (int f = 0; f < 10; f++) strobe(mk(5'd7, 5'd7, 5'd7), 4);
        tick(1350);
        strobe(mk(5'd7, 5'd7, 5'd7), 100);
        strobe(mk(5'd7, 5'd7, 5'd7), 100);
        strobe(mk(5'd20, 5'd20, 5'd20), 4);
        ap_start = 1'b0;
        strobe(mk(5'd20, 5'd20, 5'd20), 4);
        strobe(mk(5'd20, 5'd20, 5'd20), 4);
        wait_done(d0 + 2, 300);
        check("gap_pair_count", 32'(mq.size()), 32'(base + 2 * NCH));
        for (int c = 0; c < NCH; c++) check_pair(base + c, c, 5'd7, 16'd12);
        for (int c = 0; c < NCH; c++) check_pair(base + NCH + c, c, 5'd20, 16'd3);

        // Back-pressure on the mode FIFO mid-EMIT
        d = '0;
        for (int c = 0; c < NCH; c++) d[c*5 +: 5] = 5'(c);
        accumulation_V = 32'd2;
        ap_start = 1'b1;
        wait_busy();
        ap_start = 1'b0;
        base = mq.size();
        d0   = done_cnt;
        strobe(d, 4);
        strobe(d, 4);
        n = 0;
        while (mq.size() < base + 3 && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        tick(1);
        mode_out_V_V_full_n = 1'b0;
        sz     = mq.size();
        held_m = mode_out_V_V_din;
        held_f = frequency_out_V_V_din;
        stable = 1'b1;
        repeat (20) begin
            @(negedge ap_clk);
            if (mode_out_V_V_din !== held_m || frequency_out_V_V_din !== held_f) stable = 1'b0;
        end
        check("bp_no_write", 32'(mq.size()), 32'(sz));
        check("bp_stable", 32'(stable), 32'd1);
        tick(1);
        mode_out_V_V_full_n = 1'b1;
        wait_done(d0 + 1, 300);
        check("bp_pair_count", 32'(mq.size()), 32'(base + NCH));
        for (int c = 0; c < NCH; c++) check_pair(base + c, c, 5'(c), 16'd2);

        // Reset in the middle of an accumulation window
        accumulation_V = 32'd12;
        ap_start = 1'b1;
        wait_busy();
        for (int f = 0; f < 5; f++) strobe(mk(5'd7, 5'd7, 5'd7), 4);
        @(negedge ap_clk);
        #1;
        ap_rst = 1'b1;
        #1;
        check("midrst_outputs", {ap_done, ap_idle, ap_ready, mode_out_V_V_write, frequency_out_V_V_write,
                                 mode_out_V_V_din, frequency_out_V_V_din}, 32'd0);
        ap_start = 1'b0;
        tick(3);
        ap_rst = 1'b0;
        n = 0;
        while (!ap_idle && n < 100) begin
            tick(1);
            n++;
        end
        check("midrst_idle", 32'(ap_idle), 32'd1);
        vecs[0].gap = 4;
        run_row(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
